// File: rtl/ber_checker_mc_if.sv
// Port bundle for ber_checker_mc: symbol strobe, per-channel reference/received bits,
// counter control and the lock/delay/count status returned by the checker.
interface ber_checker_mc_if #(
  parameter int NCH   = 2,
  parameter int DLY_W = 9,
  parameter int CNT_W = 48,
  parameter int SEL_W = 1
);
  logic                   enable;
  logic [NCH-1:0]         i_prbs;
  logic [NCH-1:0]         i_rx;
  logic                   i_clear;
  logic [SEL_W-1:0]       i_sel;
  logic [NCH-1:0]         o_lock;
  logic [NCH*DLY_W-1:0]   o_delay;
  logic [CNT_W-1:0]       o_bit_cnt;
  logic [CNT_W-1:0]       o_err_cnt;
  logic                   o_err;

  modport master (
    output enable, i_prbs, i_rx, i_clear, i_sel,
    input  o_lock, o_delay, o_bit_cnt, o_err_cnt, o_err
  );

  modport slave (
    input  enable, i_prbs, i_rx, i_clear, i_sel,
    output o_lock, o_delay, o_bit_cnt, o_err_cnt, o_err
  );
endinterface

// File: rtl/ber_checker_mc.sv
// Multi-channel BER checker: per channel, sweeps the reference delay until a window is
// error-free, then counts bits/errors while locked and re-searches on heavy error windows.
module ber_checker_mc #(
  parameter int NCH        = 2,
  parameter int DLY_W      = 9,
  parameter int SEARCH_LEN = 511,
  parameter int LOSS_THR   = 64,
  parameter int CNT_W      = 48,
  parameter int SEL_W      = 1
) (
  input  logic             clk,
  input  logic             rst,
  ber_checker_mc_if.slave  bus
);
  localparam int LINE  = 2**DLY_W - 1;
  localparam int WIN_W = $clog2(SEARCH_LEN + 1);

  typedef enum logic {SEARCH, LOCK} state_t;

  state_t           state   [NCH];
  logic [LINE-1:0]  line    [NCH];
  logic [DLY_W-1:0] delay   [NCH];
  logic [WIN_W-1:0] win_cnt [NCH];
  logic [WIN_W-1:0] win_err [NCH];
  logic [CNT_W-1:0] bit_cnt [NCH];
  logic [CNT_W-1:0] err_cnt [NCH];
  logic             err_q;

  logic [LINE:0]    full    [NCH];
  logic [WIN_W-1:0] win_tot [NCH];
  logic [NCH-1:0]   tap, mis, locked, win_last;

  // Delay 0 taps the live input; delay d taps the bit shifted in d enables ago.
  always_comb begin
    tap      = '0;
    mis      = '0;
    locked   = '0;
    win_last = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      full[c]     = {line[c], bus.i_prbs[c]};
      tap[c]      = full[c][delay[c]];
      mis[c]      = bus.i_rx[c] ^ tap[c];
      locked[c]   = (state[c] == LOCK);
      win_last[c] = (win_cnt[c] == WIN_W'(SEARCH_LEN - 1));
      win_tot[c]  = win_err[c] + WIN_W'(mis[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        state[c]   <= SEARCH;
        line[c]    <= '0;
        delay[c]   <= '0;
        win_cnt[c] <= '0;
        win_err[c] <= '0;
        bit_cnt[c] <= '0;
        err_cnt[c] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      if (bus.enable) begin
        for (int unsigned c = 0; c < NCH; c++) begin
          line[c] <= {line[c][LINE-2:0], bus.i_prbs[c]};
          if (win_last[c]) begin
            win_cnt[c] <= '0;
            win_err[c] <= '0;
            if (state[c] == SEARCH) begin
              if (win_tot[c] == '0) state[c] <= LOCK;
              else                  delay[c] <= delay[c] + DLY_W'(1);
            end else if (win_tot[c] > WIN_W'(LOSS_THR)) begin
              state[c] <= SEARCH;
              delay[c] <= delay[c] + DLY_W'(1);
            end
          end else begin
            win_cnt[c] <= win_cnt[c] + WIN_W'(1);
            win_err[c] <= win_tot[c];
          end
          if (state[c] == LOCK) begin
            if (bit_cnt[c] != '1)          bit_cnt[c] <= bit_cnt[c] + CNT_W'(1);
            if (mis[c] && err_cnt[c] != '1) err_cnt[c] <= err_cnt[c] + CNT_W'(1);
          end
        end
      end
      // Placed after the increments so a same-cycle clear wins.
      if (bus.i_clear) begin
        for (int unsigned c = 0; c < NCH; c++) begin
          bit_cnt[c] <= '0;
          err_cnt[c] <= '0;
        end
      end
      err_q <= bus.enable & (|(mis & locked));
    end
  end

  always_comb begin
    bus.o_lock    = locked;
    bus.o_err     = err_q;
    bus.o_delay   = '0;
    bus.o_bit_cnt = '0;
    bus.o_err_cnt = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      bus.o_delay[c*DLY_W +: DLY_W] = delay[c];
      if (bus.i_sel == SEL_W'(c)) begin
        bus.o_bit_cnt = bit_cnt[c];
        bus.o_err_cnt = err_cnt[c];
      end
    end
  end
endmodule

// File: tb/tb_ber_checker_mc.sv
// Bench for ber_checker_mc: PRBS9 link with fixed channel latencies, a second instance
// with 4-bit counters for saturation, all compared against a queue-based reference model.
module tb_ber_checker_mc;
  localparam int NCH = 2, DLY_W = 9, SEL_W = 1, CW = 48, CWS = 4, SL = 511, THR = 64;
  localparam int NDLY = 2**DLY_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ber_checker_mc_if #(.NCH(NCH), .DLY_W(DLY_W), .CNT_W(CW),  .SEL_W(SEL_W)) bus ();
  ber_checker_mc_if #(.NCH(NCH), .DLY_W(DLY_W), .CNT_W(CWS), .SEL_W(SEL_W)) bus_s ();

  assign bus_s.enable  = bus.enable;
  assign bus_s.i_prbs  = bus.i_prbs;
  assign bus_s.i_rx    = bus.i_rx;
  assign bus_s.i_clear = bus.i_clear;
  assign bus_s.i_sel   = bus.i_sel;

  ber_checker_mc #(.NCH(NCH), .DLY_W(DLY_W), .SEARCH_LEN(SL), .LOSS_THR(THR),
                   .CNT_W(CW), .SEL_W(SEL_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  ber_checker_mc #(.NCH(NCH), .DLY_W(DLY_W), .SEARCH_LEN(SL), .LOSS_THR(THR),
                   .CNT_W(CWS), .SEL_W(SEL_W)) dut_sat (.clk(clk), .rst(rst), .bus(bus_s.slave));

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit     m_lock  [NCH];
  int     m_delay [NCH];
  int     m_wn    [NCH];
  int     m_we    [NCH];
  longint m_bits  [NCH];
  longint m_errs  [NCH];
  bit     m_err;
  bit     hist    [NCH][$];

  // Link stimulus state
  logic [8:0] lfsr;
  bit         gen_hist[$];
  int         en_cnt;

  function automatic longint sat(longint x, int w);
    longint cap = (longint'(1) << w) - 1;
    return (x > cap) ? cap : x;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_lock[c] = 0; m_delay[c] = 0; m_wn[c] = 0; m_we[c] = 0;
      m_bits[c] = 0; m_errs[c] = 0;
      hist[c].delete();
      repeat (NDLY) hist[c].push_back(1'b0);
    end
    m_err  = 0;
    en_cnt = 0;
  endtask

  task automatic model_step(bit en, logic [NCH-1:0] p, logic [NCH-1:0] r, bit clr);
    bit any = 0;
    bit mis;
    if (en) begin
      for (int c = 0; c < NCH; c++) begin
        hist[c].push_front(p[c]);
        void'(hist[c].pop_back());
        mis = r[c] ^ hist[c][m_delay[c]];
        m_wn[c]++;
        m_we[c] += int'(mis);
        if (m_lock[c]) begin
          m_bits[c]++;
          m_errs[c] += longint'(mis);
          any |= mis;
        end
        if (m_wn[c] == SL) begin
          if (!m_lock[c]) begin
            if (m_we[c] == 0) m_lock[c] = 1;
            else              m_delay[c] = (m_delay[c] + 1) % NDLY;
          end else if (m_we[c] > THR) begin
            m_lock[c]  = 0;
            m_delay[c] = (m_delay[c] + 1) % NDLY;
          end
          m_wn[c] = 0;
          m_we[c] = 0;
        end
      end
    end
    if (clr) for (int c = 0; c < NCH; c++) begin m_bits[c] = 0; m_errs[c] = 0; end
    m_err = en & any;
  endtask

  task automatic check_all();
    logic [NCH-1:0] el;
    int s;
    for (int c = 0; c < NCH; c++) el[c] = m_lock[c];
    chk("lock", bus.o_lock, el);
    chk("lock_sat", bus_s.o_lock, el);
    for (int c = 0; c < NCH; c++) chk("delay", bus.o_delay[c*DLY_W +: DLY_W], m_delay[c]);
    chk("err_pulse", bus.o_err, m_err);
    s = int'(bus.i_sel);
    chk("bit_cnt", bus.o_bit_cnt, sat(m_bits[s], CW));
    chk("err_cnt", bus.o_err_cnt, sat(m_errs[s], CW));
    chk("bit_cnt_sat", bus_s.o_bit_cnt, sat(m_bits[s], CWS));
    chk("err_cnt_sat", bus_s.o_err_cnt, sat(m_errs[s], CWS));
  endtask

  // One clock: ch0 sees the link 5 enables late, ch1 17 enables late.
  task automatic step(bit en, bit flip0, bit inv1, bit clr, int sel);
    logic [NCH-1:0] p, r;
    bit nb;
    if (en) begin
      nb   = lfsr[8] ^ lfsr[4];
      lfsr = {lfsr[7:0], nb};
      gen_hist.push_front(nb);
      void'(gen_hist.pop_back());
      en_cnt++;
    end
    p    = {gen_hist[0], gen_hist[0]};
    r[0] = gen_hist[5] ^ flip0;
    r[1] = gen_hist[17] ^ inv1;
    bus.enable  = en;
    bus.i_prbs  = p;
    bus.i_rx    = r;
    bus.i_clear = clr;
    bus.i_sel   = (sel < 0) ? SEL_W'($urandom_range(0, NCH - 1)) : SEL_W'(sel);
    @(posedge clk);
    #1;
    model_step(en, p, r, clr);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.enable = 1'b0; bus.i_clear = 1'b1; bus.i_sel = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.i_clear = 1'b0;
    model_reset();
    check_all();
    chk("rst_lock", bus.o_lock, 0);
    chk("rst_delay", bus.o_delay, 0);
    chk("rst_err", bus.o_err, 0);
    chk("rst_bits", bus.o_bit_cnt, 0);
    chk("rst_errs", bus.o_err_cnt, 0);
  endtask

  task automatic acquire(int period, string tag);
    int l0 = -1, l1 = -1;
    for (int k = 0; k < period * 10000 && bus.o_lock != 2'b11; k++) begin
      step((k % period) == period - 1, 0, 0, 0, -1);
      if (bus.o_lock[0] && l0 < 0) begin
        l0 = en_cnt;
        chk({tag, "_delay0"}, bus.o_delay[0 +: DLY_W], 5);
      end
      if (bus.o_lock[1] && l1 < 0) begin
        l1 = en_cnt;
        chk({tag, "_delay1"}, bus.o_delay[DLY_W +: DLY_W], 17);
      end
    end
    chk({tag, "_time0"}, l0, 6 * SL);
    chk({tag, "_time1"}, l1, 18 * SL);
  endtask

  initial begin
    int inv_n;
    bit lost;
    rst = 1'b1;
    bus.enable = 1'b0; bus.i_prbs = '0; bus.i_rx = '0; bus.i_clear = 1'b0; bus.i_sel = '0;
    lfsr = 9'($urandom_range(1, 511));
    repeat (32) gen_hist.push_back(1'b0);
    do_reset();

    // Acquisition with enable every 4th clock
    acquire(4, "acq");

    // Single flipped bit on ch0 while both locked
    repeat (10) begin step(0, 0, 0, 0, -1); step(1, 0, 0, 0, -1); end
    step(1, 1, 0, 0, 0);
    chk("flip_err_pulse", bus.o_err, 1);
    chk("flip_err0", bus.o_err_cnt, 1);
    step(0, 0, 0, 0, 1);
    chk("flip_pulse_end", bus.o_err, 0);
    chk("flip_err1", bus.o_err_cnt, 0);
    chk("flip_lock", bus.o_lock, 2'b11);

    // Inverted ch1 for a full window; lock must drop with delay 18
    inv_n = 0;
    lost  = 0;
    for (int k = 0; k < 2 * 1200 && !lost; k++) begin
      if (k % 2 == 1) begin
        step(1, 0, inv_n < SL, 0, 1);
        inv_n++;
      end else step(0, 0, 0, 0, 1);
      if (!bus.o_lock[1]) begin
        lost = 1;
        chk("loss_delay1", bus.o_delay[DLY_W +: DLY_W], 18);
        chk("loss_lock0", bus.o_lock[0], 1);
      end
    end
    chk("loss_seen", lost, 1);
    while (inv_n < SL) begin step(0, 0, 1, 0, -1); step(1, 0, 1, 0, -1); inv_n++; end

    // Clear on an erroring enable
    step(1, 1, 0, 1, 0);
    chk("clr_bits0", bus.o_bit_cnt, 0);
    chk("clr_errs0", bus.o_err_cnt, 0);
    chk("clr_lock0", bus.o_lock[0], 1);
    step(0, 0, 0, 0, 1);
    chk("clr_bits1", bus.o_bit_cnt, 0);

    // 20 locked enables saturate the 4-bit counter
    repeat (20) begin step(0, 0, 0, 0, 0); step(1, 0, 0, 0, 0); end
    chk("sat_bits", bus_s.o_bit_cnt, 15);

    // Enable held low for 100 clocks
    repeat (100) begin
      step(0, 0, 0, 0, 0);
      chk("hold_err", bus.o_err, 0);
    end
    chk("hold_sat", bus_s.o_bit_cnt, 15);
    chk("hold_lock0", bus.o_lock[0], 1);
    chk("hold_bits0", bus.o_bit_cnt, 20);

    // Reset mid-lock, then re-acquire
    do_reset();
    acquire(2, "reacq");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
